// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter-legality rules for the programmable synchronous FIFO.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // The count must reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        bit ok;
        ok = 1'b1;
        if (data_w < 1) ok = 1'b0;
        if (depth < 4 || (depth & (depth - 1)) != 0) ok = 1'b0;
        if (af_level < 1 || af_level > depth - 1) ok = 1'b0;
        if (ae_level < 0 || ae_level > depth - 2 || ae_level >= af_level) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port that is either registered or asynchronous.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int REG_RD = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic                      i_re,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem_q[i_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = (REG_RD != 0) ? rdata_q : mem_q[i_raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Parametrised single-clock FIFO with programmable almost levels, standard/FWFT read and sticky errors.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wren,
    input  logic [DATA_W-1:0]      i_wrdata,
    input  logic                   i_rden,
    input  logic                   i_clr_err,
    output logic [DATA_W-1:0]      o_rddata,
    output logic                   o_rd_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_alm_full,
    output logic                   o_alm_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
        $error("fifo_sync_prog: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic full_q, full_d, empty_q, empty_d;
    logic alm_full_q, alm_full_d, alm_empty_q, alm_empty_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic rd_valid_q, rd_valid_d;
    logic wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        wr_acc   = i_wren && !full_q;
        rd_acc   = i_rden && !empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
        // Flags are computed from the post-edge count so they line up with o_count.
        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        alm_full_d  = (count_d >= CNT_W'(AF_LEVEL));
        alm_empty_d = (count_d <= CNT_W'(AE_LEVEL));
        rd_valid_d  = rd_acc;
        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d = (i_wren && full_q)  ? 1'b1 : (i_clr_err ? 1'b0 : ovf_q);
        unf_d = (i_rden && empty_q) ? 1'b1 : (i_clr_err ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REG_RD ((FWFT == 0) ? 1 : 0)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (wr_acc),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_wrdata),
        .i_re    (rd_acc),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

    // In FWFT mode the head slot is masked while empty so stale or unwritten storage never shows.
    assign o_rddata    = (FWFT != 0) ? (empty_q ? '0 : ram_rdata) : ram_rdata;
    assign o_rd_valid  = (FWFT != 0) ? !empty_q : rd_valid_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: standard and FWFT instances share stimulus and one queue-based model.
module tb_fifo_sync_prog;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic wren = 1'b0, rden = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] wrdata = '0;

    logic [DW-1:0] s_rddata, f_rddata;
    logic s_rdv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic f_rdv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rddata = '0;
    logic m_rdv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    int m_sz;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .i_clr_err(clr_err), .o_rddata(s_rddata), .o_rd_valid(s_rdv), .o_full(s_full),
        .o_empty(s_empty), .o_alm_full(s_af), .o_alm_empty(s_ae), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    fifo_sync_prog #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fw (
        .clk(clk), .reset(reset), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .i_clr_err(clr_err), .o_rddata(f_rddata), .o_rd_valid(f_rdv), .o_full(f_full),
        .o_empty(f_empty), .o_alm_full(f_af), .o_alm_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the visible read register and sticky flags.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_rddata = '0;
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_sz = exp_q.size();
            m_rdv = rden && (m_sz > 0);
            if (m_rdv) m_rddata = exp_q.pop_front();
            if (wren && (m_sz < DEPTH)) exp_q.push_back(wrdata);
            if (wren && (m_sz == DEPTH)) m_ovf = 1'b1;
            else if (clr_err) m_ovf = 1'b0;
            if (rden && (m_sz == 0)) m_unf = 1'b1;
            else if (clr_err) m_unf = 1'b0;
        end
    end

    task automatic cmp_common(input string tag, input logic [4:0] cnt, input logic full,
                              input logic empty, input logic af, input logic ae,
                              input logic ovf, input logic unf);
        int sz;
        sz = exp_q.size();
        check({tag, "_count"}, DW'(cnt), DW'(sz));
        check({tag, "_full"}, DW'(full), DW'(sz == DEPTH));
        check({tag, "_empty"}, DW'(empty), DW'(sz == 0));
        check({tag, "_alm_full"}, DW'(af), DW'(sz >= AF));
        check({tag, "_alm_empty"}, DW'(ae), DW'(sz <= AE));
        check({tag, "_overflow"}, DW'(ovf), DW'(m_ovf));
        check({tag, "_underflow"}, DW'(unf), DW'(m_unf));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_common("std", s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf);
            cmp_common("fw", f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf);
            check("std_rddata", s_rddata, m_rddata);
            check("std_rd_valid", DW'(s_rdv), DW'(m_rdv));
            check("fw_rddata", f_rddata, (exp_q.size() > 0) ? exp_q[0] : '0);
            check("fw_rd_valid", DW'(f_rdv), DW'(exp_q.size() > 0));
        end
    end

    task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] d);
        wren = wr;
        rden = rd;
        clr_err = clr;
        wrdata = d;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int wbias;
        // Reset state
        do_reset(2);
        chk_en = 1'b1;
        check("rst_empty", DW'(s_empty), DW'(1));
        check("rst_alm_empty", DW'(s_ae), DW'(1));
        check("rst_full", DW'(s_full), DW'(0));
        check("rst_count", DW'(s_count), DW'(0));
        check("rst_rddata", s_rddata, DW'(0));
        check("rst_fw_rddata", f_rddata, DW'(0));
        check("rst_errors", DW'({s_ovf, s_unf}), DW'(0));

        // Fill with 0..15, then one write too many
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, DW'(i));
            check("fill_alm_empty", DW'(s_ae), DW'((i + 1) <= 2));
            check("fill_alm_full", DW'(s_af), DW'((i + 1) >= 12));
            check("fill_full", DW'(s_full), DW'((i + 1) == 16));
        end
        check("fill_fw_head", f_rddata, DW'(0));
        cycle(1'b1, 1'b0, 1'b0, DW'(99));
        check("ovf_set", DW'(s_ovf), DW'(1));
        check("ovf_count", DW'(s_count), DW'(16));

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check("drain_data", s_rddata, DW'(i));
            check("drain_valid", DW'(s_rdv), DW'(1));
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("unf_set", DW'(s_unf), DW'(1));
        check("unf_hold_data", s_rddata, DW'(15));
        check("unf_valid_low", DW'(s_rdv), DW'(0));
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("clr_errors", DW'({s_ovf, s_unf}), DW'(0));

        // Simultaneous read/write at mid-level and at full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, rand_word());
            check("rw_count8", DW'(s_count), DW'(8));
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
        cycle(1'b1, 1'b1, 1'b0, rand_word());
        check("rw_full_count", DW'(s_count), DW'(15));
        check("rw_full_ovf", DW'(s_ovf), DW'(1));
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("rw_clr_ovf", DW'(s_ovf), DW'(0));

        // 40 interleaved transfers to wrap the pointers
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, rand_word());
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // FWFT fall-through into an empty FIFO
        do_reset(1);
        cycle(1'b1, 1'b0, 1'b0, DW'('hA5));
        check("fwft_data", f_rddata, DW'('hA5));
        check("fwft_valid", DW'(f_rdv), DW'(1));
        check("std_no_valid", DW'(s_rdv), DW'(0));

        // Reset mid-fill discards contents
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
        do_reset(1);
        check("midrst_count", DW'(f_count), DW'(0));
        check("midrst_empty", DW'(f_empty), DW'(1));
        check("midrst_fw_data", f_rddata, DW'(0));

        // Randomized traffic with fill/drain phases, clears and occasional resets
        wbias = 80;
        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 0) wbias = (wbias == 80) ? 25 : 80;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) >= wbias - 10),
                      ($urandom_range(0, 31) == 0), rand_word());
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
